// File: rtl/bcd_time_counter_if.sv
// Control and display bundle for bcd_time_counter.
// The master drives the run/preset/rate controls; the slave returns the count and its strobes.
interface bcd_time_counter_if #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned DIV_W      = 28
);
  logic                    run;
  logic                    up;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic [DIV_W-1:0]        lim;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [7*NUM_DIGITS-1:0] hex;
  logic                    tick;
  logic                    wrap;

  modport master (
    output run, up, load, load_value, lim,
    input  bcd, hex, tick, wrap
  );

  modport slave (
    input  run, up, load, load_value, lim,
    output bcd, hex, tick, wrap
  );
endinterface

// File: rtl/bcd_time_counter.sv
// Multi-digit BCD modulo counter with a programmable tick divider, preset load,
// up/down direction, a wrap pulse for cascading and per-digit seven-segment decode.
module bcd_time_counter #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned MOD        = 24,
  parameter int unsigned DIV_W      = 28
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  bcd_time_counter_if.slave bus
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  x;
    r = '0;
    x = v;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      r[4*d+:4] = 4'(x % 10);
      x         = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  localparam logic [W-1:0] MaxBcd = to_bcd(MOD - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [W-1:0]     bcd_q, bcd_d;
  logic             wrap_q, wrap_d;

  logic [W-1:0]     inc_val, dec_val;
  logic             load_ok;
  int unsigned      load_bin;

  assign bus.tick = bus.run && (div_q == '0);
  assign bus.bcd  = bcd_q;
  assign bus.wrap = wrap_q;

  // Ripple increment/decrement across digits; only used when not at a wrap boundary.
  always_comb begin
    logic carry;
    logic borrow;
    inc_val = bcd_q;
    dec_val = bcd_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (carry) begin
        if (inc_val[4*d+:4] == 4'd9) begin
          inc_val[4*d+:4] = 4'd0;
        end else begin
          inc_val[4*d+:4] = inc_val[4*d+:4] + 4'd1;
          carry           = 1'b0;
        end
      end
      if (borrow) begin
        if (dec_val[4*d+:4] == 4'd0) begin
          dec_val[4*d+:4] = 4'd9;
        end else begin
          dec_val[4*d+:4] = dec_val[4*d+:4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  always_comb begin
    load_ok  = 1'b1;
    load_bin = 0;
    for (int d = int'(NUM_DIGITS) - 1; d >= 0; d--) begin
      if (bus.load_value[4*d+:4] > 4'd9) load_ok = 1'b0;
      load_bin = load_bin * 10 + 32'(bus.load_value[4*d+:4]);
    end
    if (load_bin >= MOD) load_ok = 1'b0;
  end

  always_comb begin
    div_d  = div_q;
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      bcd_d = load_ok ? bus.load_value : '0;
      div_d = bus.lim;
    end else begin
      if (bus.run) begin
        div_d = (div_q == '0) ? bus.lim : div_q - DIV_W'(1);
      end
      if (bus.tick) begin
        if (bus.up) begin
          if (bcd_q == MaxBcd) begin
            bcd_d  = '0;
            wrap_d = 1'b1;
          end else begin
            bcd_d = inc_val;
          end
        end else begin
          if (bcd_q == '0) begin
            bcd_d  = MaxBcd;
            wrap_d = 1'b1;
          end else begin
            bcd_d = dec_val;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    bus.hex = '1;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      bus.hex[7*d+:7] = seg7(bcd_q[4*d+:4]);
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: expected count/wrap pushed to a scoreboard queue
// as each step is driven, popped and compared once the DUT has taken the step.
module tb_bcd_time_counter;

  localparam int unsigned NumDigits = 2;
  localparam int unsigned Mod       = 24;
  localparam int unsigned DivW      = 28;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_time_counter_if #(.NUM_DIGITS(NumDigits), .DIV_W(DivW)) bus ();

  bcd_time_counter #(
    .NUM_DIGITS(NumDigits),
    .MOD       (Mod),
    .DIV_W     (DivW)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] bcd;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   w;
  logic seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] b, input logic wr);
    exp_t e;
    e.tag  = tag;
    e.bcd  = b;
    e.wrap = wr;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_bcd"}, 32'(bus.bcd), 32'(e.bcd));
      check({e.tag, "_wrap"}, 32'(bus.wrap), 32'(e.wrap));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges elapsed before tick is seen high (bounded).
  task automatic wait_tick(input int budget, output int waits);
    #1;
    waits = 0;
    while (bus.tick !== 1'b1 && waits < budget) begin
      cyc();
      waits++;
    end
    check("tick_seen", 32'(bus.tick), 32'd1);
  endtask

  task automatic advance(input int n, input int period);
    int wt;
    for (int i = 0; i < n; i++) begin
      wait_tick(64, wt);
      if (i > 0) check("period", 32'(wt + 1), 32'(period));
      cyc();
    end
  endtask

  task automatic load_val(input logic [7:0] v);
    bus.load       = 1'b1;
    bus.load_value = v;
    cyc();
    bus.load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run        = 1'b0;
    bus.up         = 1'b1;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.lim        = 28'd3;
    reset          = 1'b1;
    #2 reset = 1'b0;
    #1;
    push_exp("rst", 8'h00, 1'b0);
    pop_check();
    check("rst_hex", 32'(bus.hex), 32'(14'b1000000_1000000));
    check("rst_tick", 32'(bus.tick), 32'd0);

    @(negedge clk) reset = 1'b1;
    repeat (5) cyc();
    push_exp("hold", 8'h00, 1'b0);
    pop_check();

    // Rate and carry at lim=3
    bus.run = 1'b1;
    #1;
    check("first_tick", 32'(bus.tick), 32'd1);
    push_exp("ten", 8'h10, 1'b0);
    advance(10, 4);
    pop_check();
    check("hex_10", 32'(bus.hex), 32'(14'b1111001_1000000));
    push_exp("t23", 8'h23, 1'b0);
    advance(13, 4);
    pop_check();
    check("hex_23", 32'(bus.hex), 32'(14'b0100100_0110000));

    // Wrap in both directions
    load_val(8'h23);
    push_exp("ld23", 8'h23, 1'b0);
    pop_check();
    push_exp("wrap_up", 8'h00, 1'b1);
    advance(1, 4);
    pop_check();
    cyc();
    push_exp("wrap_up_end", 8'h00, 1'b0);
    pop_check();
    bus.up = 1'b0;
    push_exp("wrap_dn", 8'h23, 1'b1);
    advance(1, 4);
    pop_check();
    cyc();
    push_exp("wrap_dn_end", 8'h23, 1'b0);
    pop_check();
    load_val(8'h10);
    push_exp("ld10", 8'h10, 1'b0);
    pop_check();
    push_exp("borrow", 8'h09, 1'b0);
    advance(1, 4);
    pop_check();
    check("hex_09", 32'(bus.hex), 32'(14'b1000000_0010000));

    // Load edge cases
    load_val(8'h2A);
    push_exp("ld_2a", 8'h00, 1'b0);
    pop_check();
    load_val(8'h12);
    push_exp("ld_12", 8'h12, 1'b0);
    pop_check();
    load_val(8'h30);
    push_exp("ld_30", 8'h00, 1'b0);
    pop_check();
    bus.up = 1'b1;
    load_val(8'h23);
    wait_tick(64, w);
    load_val(8'h05);
    push_exp("ld_on_tick", 8'h05, 1'b0);
    pop_check();
    wait_tick(64, w);
    check("ld_period", 32'(w + 1), 32'd4);
    cyc();

    // Pause and lim change at lim=9
    bus.lim = 28'd9;
    wait_tick(64, w);
    cyc();
    repeat (3) cyc();
    bus.run = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      seen = seen | bus.tick;
    end
    push_exp("pause", 8'h07, 1'b0);
    pop_check();
    check("pause_tick", 32'(seen), 32'd0);
    bus.run = 1'b1;
    wait_tick(64, w);
    check("resume_gap", 32'(w + 1), 32'd7);
    cyc();
    repeat (2) cyc();
    bus.lim = 28'd1;
    wait_tick(64, w);
    check("lim_old_period", 32'(w + 3), 32'd10);
    cyc();
    wait_tick(64, w);
    check("lim_new_period_a", 32'(w + 1), 32'd2);
    cyc();
    wait_tick(64, w);
    check("lim_new_period_b", 32'(w + 1), 32'd2);
    cyc();
    push_exp("after_lim", 8'h11, 1'b0);
    pop_check();

    // Asynchronous reset mid-count, then full-rate counting
    load_val(8'h17);
    push_exp("ld17", 8'h17, 1'b0);
    pop_check();
    #3 reset = 1'b0;
    #1;
    push_exp("async_rst", 8'h00, 1'b0);
    pop_check();
    check("async_hex", 32'(bus.hex), 32'(14'b1000000_1000000));
    bus.lim = 28'd0;
    @(negedge clk) reset = 1'b1;
    cyc();
    push_exp("restart", 8'h01, 1'b0);
    pop_check();
    repeat (22) cyc();
    push_exp("fast23", 8'h23, 1'b0);
    pop_check();
    cyc();
    push_exp("fast_wrap", 8'h00, 1'b1);
    pop_check();
    cyc();
    push_exp("fast_01", 8'h01, 1'b0);
    pop_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
